// File: rtl/imm_gen_stage.sv
// Immediate-decode pipeline stage.
// Classifies each instruction from its opcode, builds the XLEN-bit immediate
// and passes it downstream through an output register backed by one skid
// entry, so one instruction per cycle flows even under back-pressure.
module imm_gen_stage #(
  parameter int XLEN    = 32,
  parameter int ZIMM_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_U = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;
  localparam logic [2:0] FMT_X = 3'd7;

  logic [6:0]        opcode;
  logic [2:0]        dec_fmt;
  logic [XLEN-1:0]   dec_imm;

  // Raw immediate fields; declared signed so the size cast sign-extends.
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;

  logic              skid_valid;
  logic [XLEN-1:0]   skid_imm;
  logic [2:0]        skid_fmt;

  assign opcode = in_inst[6:0];
  assign imm_i  = in_inst[31:20];
  assign imm_s  = {in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j  = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};

  // Opcode classification into a format code.
  always_comb begin
    dec_fmt = FMT_X;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: dec_fmt = FMT_I;
      7'b0011011: dec_fmt = (XLEN == 64) ? FMT_I : FMT_X;
      7'b1110011: dec_fmt = (in_inst[14] && (ZIMM_EN != 0)) ? FMT_Z : FMT_I;
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: dec_fmt = FMT_B;
      7'b1101111: dec_fmt = FMT_J;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b0110011: dec_fmt = FMT_R;
      default:    dec_fmt = FMT_X;
    endcase
  end

  // Immediate selection; R and illegal formats carry zero.
  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I:   dec_imm = XLEN'(imm_i);
      FMT_S:   dec_imm = XLEN'(imm_s);
      FMT_B:   dec_imm = XLEN'(imm_b);
      FMT_J:   dec_imm = XLEN'(imm_j);
      FMT_U:   dec_imm = XLEN'(imm_u);
      FMT_Z:   dec_imm = XLEN'(in_inst[19:15]);
      default: dec_imm = '0;
    endcase
  end

  // A held skid entry means the output register is also full, so stall input.
  assign in_ready    = !skid_valid;
  assign out_illegal = (out_fmt == FMT_X);

  // Output register plus skid entry; flush drops both, data left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_fmt    <= FMT_R;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_R;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_imm    <= skid_imm;
        out_fmt    <= skid_fmt;
        skid_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_imm   <= dec_imm;
        out_fmt   <= dec_fmt;
      end else begin
        skid_valid <= 1'b1;
        skid_imm   <= dec_imm;
        skid_fmt   <= dec_fmt;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-decode stage between fetch and execute.
- Accepts one 32-bit instruction per cycle through a valid/ready handshake.
- Classifies the instruction format from its opcode and emits a single sign- or zero-extended XLEN-bit immediate, a format code and an illegal flag.
- A 2-entry skid buffer sustains full throughput under downstream back-pressure; a synchronous flush discards in-flight entries on redirect.

Parameters:
- XLEN, 32, output immediate width; 32 or 64. 64 also enables OP-IMM-32 (0011011) as I-type.
- ZIMM_EN, 1, 1: SYSTEM with funct3[2]=1 decodes as Z (zero-extended 5-bit zimm). 0: such instructions decode as I.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; clears both buffer entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; equals !skid_valid
- in_inst  in  32  instruction word
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  format code: R=0, I=1, S=2, B=3, J=4, U=5, Z=6, X(illegal)=7
- out_illegal  out  1  opcode not recognised (out_fmt==7)

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid_valid=0, out_imm=0, out_fmt=0, out_illegal=0. in_ready=1.
- Decode map on in_inst[6:0]:
  - I: 0000011, 0010011, 1100111, 0011011 (XLEN=64 only), 1110011 with funct3[2]=0.
  - Z: 1110011 with funct3[2]=1 and ZIMM_EN=1.
  - S: 0100011. B: 1100011. J: 1101111. U: 0110111, 0010111. R: 0110011.
  - 0011011 with XLEN=32, and all other opcodes: X.
- Immediate construction:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25],inst[11:7]}).
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - U: sext({inst[31:12],12'b0}); sign-extends to XLEN.
  - Z: zext(inst[19:15]).
  - R and X: 0.
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency is 1 cycle: an accepted instruction appears on out_* the next cycle when the output register is empty or draining.
- Accepting while the output register holds an entry and out_ready=0: new entry goes to the skid register; skid_valid=1, so in_ready=0 next cycle.
- Output transfer with skid_valid=1: skid moves to the output register and skid_valid clears. An input cannot be accepted that cycle because in_ready=0.
- Output transfer, skid empty, input accepted same cycle: the new entry loads the output register; out_valid stays 1.
- Output transfer, no input: out_valid goes to 0.
- out_* hold stable while out_valid=1 && out_ready=0.
- Order is strictly preserved; no entry is duplicated or dropped except by flush.
- flush=1: next cycle out_valid=0 and skid_valid=0. An input handshaken in the same cycle is discarded. Flush overrides all simultaneous transfers.
- Data registers need not clear on flush; out_imm/out_fmt are don't-care while out_valid=0.
- Reset asserted mid-transfer: all entries lost immediately; no output handshake completes.

Test Plan:
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1. Then 0xFE20AE23 -> out_imm=0xFFFFFFFC, out_fmt=2.
- Back-to-back 0xFE000CE3 (beq, -8), 0x0010006F (jal, +2048), 0x800000B7 (lui), all with out_ready=1:
  - B: 0xFFFFFFF8, fmt 3.
  - J: 0x00000800, fmt 4.
  - U: 0x80000000 fmt 5; with XLEN=64, 0xFFFFFFFF80000000.
  - One output per cycle; in_ready stays 1.
- 0x300FD073 (csrrwi) -> ZIMM_EN=1: out_imm=0x1F, fmt 6. ZIMM_EN=0: out_imm=0x00000300, fmt 1.
- Back-pressure: hold out_ready=0, stream 3 instructions -> first two accepted; in_ready=0 from the cycle after the second. Outputs hold stable. Release out_ready -> instructions 1, 2, 3 emerge in order with no loss or duplication.
- Opcode 0x7F, and 0011011 with XLEN=32 -> out_fmt=7, out_illegal=1, out_imm=0. 0x002081B3 (add) -> fmt 0, illegal=0.
- Skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input never appears. rst_n pulsed low mid-stream -> out_valid drops asynchronously.
